// File: rtl/fft_sym_ctrl_pkg.sv
// Shared types and frame constants for the FFT symbol sequencer.
// The FFT size and CP lengths match the values frame_sync uses.
package fft_sym_ctrl_pkg;

  localparam int FFT_LEN = 256;
  localparam int CP1_LEN = 20;
  localparam int CP2_LEN = 18;

  typedef enum logic [1:0] {
    SYM_DATA = 2'd0,
    SYM_PBCH = 2'd1,
    SYM_SSS  = 2'd2
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_FWD  = 2'd2
  } state_t;

endpackage

// File: rtl/fft_sym_ctrl_ssb_tag_seq.sv
// SSB tag sequencer: PBCH_start arms a PBCH/SSS/PBCH run over the next three
// symbols; a lone SSS_start tags just the next symbol.
module ssb_tag_seq
  import fft_sym_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pbch_start,
  input  logic sss_start,
  input  logic consume,
  output sym_t tag
);

  logic [1:0] seq;
  logic       sss_pend;

  always_comb begin
    tag = SYM_DATA;
    case (seq)
      2'd3, 2'd1: tag = SYM_PBCH;
      2'd2:       tag = SYM_SSS;
      default:    if (sss_pend) tag = SYM_SSS;
    endcase
  end

  // Arming wins over consumption so a start pulse coincident with
  // symbol_start applies to the following symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq      <= 2'd0;
      sss_pend <= 1'b0;
    end else begin
      if (pbch_start)
        seq <= 2'd3;
      else if (consume && seq != 2'd0)
        seq <= seq - 2'd1;

      if (sss_start && seq == 2'd0)
        sss_pend <= 1'b1;
      else if (consume)
        sss_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_sym_ctrl.sv
// Strips the cyclic prefix (minus a timing advance) from each OFDM symbol and
// forwards FFT_LEN tagged samples with tlast to the FFT, one cycle later.
module fft_sym_ctrl #(
  parameter int IN_DW      = 32,
  parameter int FFT_LEN    = fft_sym_ctrl_pkg::FFT_LEN,
  parameter int MAX_CP_LEN = fft_sym_ctrl_pkg::CP1_LEN,
  parameter int CP_ADVANCE = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [IN_DW-1:0]              s_axis_in_tdata,
  input  logic                          s_axis_in_tvalid,
  input  logic                          symbol_start_i,
  input  logic [$clog2(MAX_CP_LEN)-1:0] CP_len_i,
  input  logic                          PBCH_start_i,
  input  logic                          SSS_start_i,
  output logic [IN_DW-1:0]              m_axis_out_tdata,
  output logic                          m_axis_out_tvalid,
  output logic                          m_axis_out_tlast,
  output logic [1:0]                    m_axis_out_tuser,
  output logic                          fft_start_o,
  output logic                          abort_o,
  output logic                          cp_err_o
);
  import fft_sym_ctrl_pkg::*;

  localparam int CPW = $clog2(MAX_CP_LEN);
  localparam int SKW = $clog2(MAX_CP_LEN + 1);
  localparam int FCW = $clog2(FFT_LEN);

  state_t           state;
  logic [SKW-1:0]   skip;
  logic [SKW-1:0]   cnt;
  logic [FCW-1:0]   fcnt;
  sym_t             win_tag;
  sym_t             tag_cur;

  logic [IN_DW-1:0] data_p1;
  logic             vld_p1;
  logic             last_p1;
  logic             start_p1;
  logic             abort_p1;
  logic             cp_err_p1;
  sym_t             tuser_p1;

  logic             start_beat;
  logic             cp_small;
  logic [SKW-1:0]   skip_new;
  logic             fcnt_last;

  assign start_beat = s_axis_in_tvalid && symbol_start_i;
  assign cp_small   = CP_len_i < CPW'(CP_ADVANCE);
  assign skip_new   = cp_small ? '0 : (SKW'(CP_len_i) - SKW'(CP_ADVANCE));
  assign fcnt_last  = fcnt == FCW'(FFT_LEN - 1);

  ssb_tag_seq u_tag_seq (
    .clk        (clk_i),
    .rst        (reset_i),
    .pbch_start (PBCH_start_i),
    .sss_start  (SSS_start_i),
    .consume    (start_beat),
    .tag        (tag_cur)
  );

  // Stage p0 -> p1: one beat in, one output slot out.
  // When a restart lands on a beat that cannot be forwarded (abort or tlast
  // slot) and skip is 0, the window begins on the following beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      skip      <= '0;
      cnt       <= '0;
      fcnt      <= '0;
      win_tag   <= SYM_DATA;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      start_p1  <= 1'b0;
      abort_p1  <= 1'b0;
      cp_err_p1 <= 1'b0;
      tuser_p1  <= SYM_DATA;
    end else begin
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      start_p1  <= 1'b0;
      abort_p1  <= 1'b0;
      cp_err_p1 <= 1'b0;
      if (s_axis_in_tvalid) begin
        data_p1 <= s_axis_in_tdata;
        if (symbol_start_i) begin
          cp_err_p1 <= cp_small;
          win_tag   <= tag_cur;
          skip      <= skip_new;
          if (state == ST_FWD && fcnt_last) begin
            vld_p1   <= 1'b1;
            last_p1  <= 1'b1;
            tuser_p1 <= win_tag;
          end else begin
            abort_p1 <= (state != ST_IDLE);
          end
          if (skip_new == '0) begin
            state <= ST_FWD;
            if (state == ST_IDLE) begin
              vld_p1   <= 1'b1;
              start_p1 <= 1'b1;
              tuser_p1 <= tag_cur;
              fcnt     <= FCW'(1);
            end else begin
              fcnt <= '0;
            end
          end else begin
            state <= ST_SKIP;
            cnt   <= SKW'(1);
          end
        end else begin
          case (state)
            ST_SKIP: begin
              if (cnt == skip) begin
                vld_p1   <= 1'b1;
                start_p1 <= 1'b1;
                tuser_p1 <= win_tag;
                fcnt     <= FCW'(1);
                state    <= ST_FWD;
              end else begin
                cnt <= cnt + SKW'(1);
              end
            end
            ST_FWD: begin
              vld_p1   <= 1'b1;
              start_p1 <= (fcnt == '0);
              last_p1  <= fcnt_last;
              tuser_p1 <= win_tag;
              if (fcnt_last)
                state <= ST_IDLE;
              else
                fcnt <= fcnt + FCW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign m_axis_out_tdata  = data_p1;
  assign m_axis_out_tvalid = vld_p1;
  assign m_axis_out_tlast  = last_p1;
  assign m_axis_out_tuser  = tuser_p1;
  assign fft_start_o       = start_p1;
  assign abort_o           = abort_p1;
  assign cp_err_o          = cp_err_p1;

endmodule

// File: tb/tb_fft_sym_ctrl.sv
// Directed bench for fft_sym_ctrl: CP strip, tagging, abort, back-to-back,
// CP error and mid-window reset.
module tb_fft_sym_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] s_axis_in_tdata;
  logic        s_axis_in_tvalid;
  logic        symbol_start_i;
  logic [4:0]  CP_len_i;
  logic        PBCH_start_i;
  logic        SSS_start_i;
  logic [31:0] m_axis_out_tdata;
  logic        m_axis_out_tvalid;
  logic        m_axis_out_tlast;
  logic [1:0]  m_axis_out_tuser;
  logic        fft_start_o;
  logic        abort_o;
  logic        cp_err_o;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  fft_sym_ctrl #(
    .IN_DW(32), .FFT_LEN(256), .MAX_CP_LEN(20), .CP_ADVANCE(4)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .s_axis_in_tdata   (s_axis_in_tdata),
    .s_axis_in_tvalid  (s_axis_in_tvalid),
    .symbol_start_i    (symbol_start_i),
    .CP_len_i          (CP_len_i),
    .PBCH_start_i      (PBCH_start_i),
    .SSS_start_i       (SSS_start_i),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .m_axis_out_tlast  (m_axis_out_tlast),
    .m_axis_out_tuser  (m_axis_out_tuser),
    .fft_start_o       (fft_start_o),
    .abort_o           (abort_o),
    .cp_err_o          (cp_err_o)
  );

  // {tvalid, tlast, fft_start, abort, cp_err, tuser, tdata}; tuser/tdata masked when idle
  function automatic logic [38:0] obs();
    return {m_axis_out_tvalid, m_axis_out_tlast, fft_start_o, abort_o, cp_err_o,
            m_axis_out_tvalid ? m_axis_out_tuser : 2'd0,
            m_axis_out_tvalid ? m_axis_out_tdata : 32'd0};
  endfunction

  function automatic logic [38:0] mk(input logic v, input logic l, input logic s,
                                     input logic a, input logic e,
                                     input logic [1:0] t, input logic [31:0] d);
    return {v, l, s, a, e, t, d};
  endfunction

  task automatic chk(input string tag, input logic [38:0] o, input logic [38:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic beat(input logic v, input logic ss, input logic [4:0] cp, input logic [31:0] d);
    s_axis_in_tvalid = v;
    symbol_start_i   = ss;
    CP_len_i         = cp;
    s_axis_in_tdata  = d;
    @(posedge clk);
    #1;
    s_axis_in_tvalid = 1'b0;
    symbol_start_i   = 1'b0;
    PBCH_start_i     = 1'b0;
    SSS_start_i      = 1'b0;
  endtask

  // Sends beats i0..n-1 of one symbol (symbol_start on beat 0) and checks each
  // output slot against the hand-derived skip, tag and window position.
  task automatic run_sym(input string tag, input int cp, input int exp_skip,
                         input logic [1:0] exp_tag, input int i0, input int n,
                         input int gap_pct, input logic [31:0] base,
                         input logic exp_cperr, input logic exp_abort);
    int  i;
    logic fwd;
    i = i0;
    while (i < n) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        beat(1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
        chk({tag, "_gap"}, obs(), mk(0, 0, 0, 0, 0, 2'd0, 32'd0));
      end else begin
        beat(1'b1, i == 0, 5'(cp), base + 32'(i));
        fwd = (i >= exp_skip) && (i < exp_skip + 256);
        chk(tag, obs(), mk(fwd, i == exp_skip + 255, i == exp_skip,
                           (i == 0) && exp_abort, (i == 0) && exp_cperr,
                           fwd ? exp_tag : 2'd0, fwd ? base + 32'(i) : 32'd0));
        i++;
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; s_axis_in_tvalid = 1'b0; symbol_start_i = 1'b0; CP_len_i = 5'd0;
    s_axis_in_tdata = 32'd0; PBCH_start_i = 1'b0; SSS_start_i = 1'b0;
    beat(1'b0, 1'b0, 5'd0, 32'd0);
    beat(1'b1, 1'b1, 5'd18, 32'h5555);
    chk("reset_outputs", obs(), 39'd0);
    chk("reset_tdata", {7'd0, m_axis_out_tdata}, 39'd0);
    reset_i = 1'b0;
    beat(1'b0, 1'b0, 5'd0, 32'd0);
    chk("idle_after_reset", obs(), 39'd0);

    // CP 18 -> 14 beats dropped, then 256 DATA samples
    run_sym("t1_cont", 18, 14, 2'd0, 0, 270, 0, 32'h1000_0000, 0, 0);
    run_sym("t2_gaps", 18, 14, 2'd0, 0, 270, 30, 32'h1000_0000, 0, 0);

    PBCH_start_i = 1'b1;
    beat(1'b0, 1'b0, 5'd0, 32'd0);
    chk("pbch_arm_idle", obs(), 39'd0);
    run_sym("t3_pbch1", 18, 14, 2'd1, 0, 270, 0, 32'h2000_0000, 0, 0);
    run_sym("t3_sss",   18, 14, 2'd2, 0, 270, 0, 32'h2100_0000, 0, 0);
    run_sym("t3_pbch2", 18, 14, 2'd1, 0, 270, 0, 32'h2200_0000, 0, 0);
    run_sym("t3_data",  18, 14, 2'd0, 0, 270, 0, 32'h2300_0000, 0, 0);
    SSS_start_i = 1'b1;
    beat(1'b0, 1'b0, 5'd0, 32'd0);
    run_sym("t3_sss_only", 18, 14, 2'd2, 0, 270, 0, 32'h2400_0000, 0, 0);

    // symbol_start on output sample 100 (input beat 114) aborts the window
    run_sym("t4_pre",     18, 14, 2'd0, 0, 114, 0, 32'h3000_0000, 0, 0);
    run_sym("t4_restart", 18, 14, 2'd0, 0, 270, 0, 32'h3100_0000, 0, 1);

    // back-to-back CP 20 then CP 18
    run_sym("t5_cp20", 20, 16, 2'd0, 0, 272, 0, 32'h4000_0000, 0, 0);
    run_sym("t5_cp18", 18, 14, 2'd0, 0, 270, 0, 32'h4100_0000, 0, 0);
    // next symbol_start coincides with the tlast beat (input beat 269)
    run_sym("t5_pre_co", 18, 14, 2'd0, 0, 269, 0, 32'h4200_0000, 0, 0);
    beat(1'b1, 1'b1, 5'd18, 32'h4300_0000);
    chk("t5_coincident_tlast", obs(), mk(1, 1, 0, 0, 0, 2'd0, 32'h4300_0000));
    run_sym("t5_after_co", 18, 14, 2'd0, 1, 270, 0, 32'h4300_0000, 0, 0);

    // CP 2 < CP_ADVANCE: cp_err, window opens on the symbol_start beat
    run_sym("t6_cperr", 2, 0, 2'd0, 0, 50, 0, 32'h5000_0000, 1, 0);
    reset_i = 1'b1;
    beat(1'b1, 1'b0, 5'd0, 32'h5000_0032);
    chk("t6_reset_mid", obs(), 39'd0);
    chk("t6_reset_tdata", {7'd0, m_axis_out_tdata}, 39'd0);
    reset_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat(1'b1, 1'b0, 5'd0, 32'h5100_0000 + 32'(k));
      chk("t6_post_reset_idle", obs(), 39'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
